// File: rtl/timer_regs_core_if.sv
// Register-access bus between the APB slave front end and the timer register bank.
// The APB slave drives the strobes, and the register bank returns read data in the same cycle.
interface timer_regs_core_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;

    modport master (output wr_en, rd_en, paddr, pwdata, pstrb, input prdata);
    modport slave  (input wr_en, rd_en, paddr, pwdata, pstrb, output prdata);
endinterface

// File: rtl/timer_regs_core.sv
// Timer register bank: control/counter/compare/interrupt registers, a 64-bit up-counter
// with a power-of-two prescaler, a debug halt and a level compare interrupt.
module timer_regs_core #(
    parameter int          ADDR_W  = 12,
    parameter int          DATA_W  = 32,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    timer_regs_core_if.slave    bus,
    input  logic                halt_req,
    output logic                interrupt,
    output logic                halt_ack
);

    localparam logic [ADDR_W-1:0] OFF_TCR   = ADDR_W'(12'h000);
    localparam logic [ADDR_W-1:0] OFF_TDR0  = ADDR_W'(12'h004);
    localparam logic [ADDR_W-1:0] OFF_TDR1  = ADDR_W'(12'h008);
    localparam logic [ADDR_W-1:0] OFF_TCMP0 = ADDR_W'(12'h00C);
    localparam logic [ADDR_W-1:0] OFF_TCMP1 = ADDR_W'(12'h010);
    localparam logic [ADDR_W-1:0] OFF_TIER  = ADDR_W'(12'h014);
    localparam logic [ADDR_W-1:0] OFF_TISR  = ADDR_W'(12'h018);

    logic        timer_en_q, timer_en_d;
    logic        div_en_q,   div_en_d;
    logic [3:0]  div_val_q,  div_val_d;
    logic [7:0]  div_cnt_q,  div_cnt_d;
    logic [63:0] cnt_q,      cnt_d;
    logic [63:0] cmp_q,      cmp_d;
    logic        int_en_q,   int_en_d;
    logic        int_st_q,   int_st_d;
    logic        halt_ack_q;

    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        div_lim;
    logic [8:0]        div_pow;
    logic              active;
    logic              tick;
    logic              match;
    logic              unused_addr_bits;

    assign word_addr        = {bus.paddr[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^bus.paddr[1:0];
    assign active           = timer_en_q & ~halt_ack_q;
    assign match            = (cnt_q == cmp_q);
    assign div_pow          = 9'd1 << div_val_q;
    assign div_lim          = 8'(div_pow - 9'd1);

    // Byte-lane merge of write data into an existing 32-bit register image.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [DATA_W/8-1:0] strb);
        logic [DATA_W-1:0] res;
        for (int i = 0; i < DATA_W/8; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        tick      = 1'b0;
        div_cnt_d = div_cnt_q;
        if (!timer_en_q) begin
            div_cnt_d = '0;
        end else if (active) begin
            if (!div_en_q) begin
                tick = 1'b1;
            end else if (div_cnt_q == div_lim) begin
                tick      = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        timer_en_d = timer_en_q;
        div_en_d   = div_en_q;
        div_val_d  = div_val_q;
        cnt_d      = tick ? cnt_q + 64'd1 : cnt_q;
        cmp_d      = cmp_q;
        int_en_d   = int_en_q;
        int_st_d   = int_st_q;

        if (bus.wr_en) begin
            unique case (word_addr)
                OFF_TCR: begin
                    if (bus.pstrb[0]) timer_en_d = bus.pwdata[0];
                    // Prescaler configuration is frozen while the timer runs.
                    if (!timer_en_q) begin
                        if (bus.pstrb[0]) div_en_d = bus.pwdata[1];
                        if (bus.pstrb[1] && bus.pwdata[11:8] <= 4'd8) div_val_d = bus.pwdata[11:8];
                    end
                end
                OFF_TDR0:  cnt_d = {cnt_q[63:32], lane_merge(cnt_q[31:0], bus.pwdata, bus.pstrb)};
                OFF_TDR1:  cnt_d = {lane_merge(cnt_q[63:32], bus.pwdata, bus.pstrb), cnt_q[31:0]};
                OFF_TCMP0: cmp_d = {cmp_q[63:32], lane_merge(cmp_q[31:0], bus.pwdata, bus.pstrb)};
                OFF_TCMP1: cmp_d = {lane_merge(cmp_q[63:32], bus.pwdata, bus.pstrb), cmp_q[31:0]};
                OFF_TIER:  if (bus.pstrb[0]) int_en_d = bus.pwdata[0];
                OFF_TISR:  if (bus.pstrb[0] && bus.pwdata[0]) int_st_d = 1'b0;
                default: ;
            endcase
        end

        // A match in the same cycle as a clear keeps the interrupt pending.
        if (match) int_st_d = 1'b1;
    end

    always_comb begin
        bus.prdata = '0;
        if (bus.rd_en) begin
            unique case (word_addr)
                OFF_TCR:   bus.prdata = {20'b0, div_val_q, 6'b0, div_en_q, timer_en_q};
                OFF_TDR0:  bus.prdata = cnt_q[31:0];
                OFF_TDR1:  bus.prdata = cnt_q[63:32];
                OFF_TCMP0: bus.prdata = cmp_q[31:0];
                OFF_TCMP1: bus.prdata = cmp_q[63:32];
                OFF_TIER:  bus.prdata = {31'b0, int_en_q};
                OFF_TISR:  bus.prdata = {31'b0, int_st_q};
                default:   bus.prdata = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_en_q <= 1'b0;
            div_en_q   <= 1'b0;
            div_val_q  <= '0;
            div_cnt_q  <= '0;
            cnt_q      <= '0;
            cmp_q      <= CMP_RST;
            int_en_q   <= 1'b0;
            int_st_q   <= 1'b0;
            halt_ack_q <= 1'b0;
        end else begin
            timer_en_q <= timer_en_d;
            div_en_q   <= div_en_d;
            div_val_q  <= div_val_d;
            div_cnt_q  <= div_cnt_d;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            int_en_q   <= int_en_d;
            int_st_q   <= int_st_d;
            halt_ack_q <= halt_req;
        end
    end

    assign interrupt = int_st_q & int_en_q;
    assign halt_ack  = halt_ack_q;

endmodule

// File: tb/tb_timer_regs_core.sv
// Self-checking bench for timer_regs_core: directed scenarios plus randomized register
// traffic, compared against a transaction-level model of the timer kept in the bench.
module tb_timer_regs_core;

    logic clk = 1'b0;
    logic rst_n;
    logic halt_req;
    logic interrupt;
    logic halt_ack;

    timer_regs_core_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    timer_regs_core #(.ADDR_W(12), .DATA_W(32), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .halt_req  (halt_req),
        .interrupt (interrupt),
        .halt_ack  (halt_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit halt_lvl = 1'b0;

    // Model state: architectural view of the timer.
    logic [63:0] m_cnt, m_cmp;
    bit          m_ten, m_den, m_ien, m_ist, m_hack;
    logic [3:0]  m_dval;
    int          m_phase;

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = '0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ten = 0; m_den = 0; m_dval = '0; m_ien = 0; m_ist = 0; m_hack = 0; m_phase = 0;
    endtask

    function automatic logic [31:0] mread(input logic [11:0] addr);
        case ({addr[11:2], 2'b00})
            12'h000: return {20'b0, m_dval, 6'b0, m_den, m_ten};
            12'h004: return m_cnt[31:0];
            12'h008: return m_cnt[63:32];
            12'h00C: return m_cmp[31:0];
            12'h010: return m_cmp[63:32];
            12'h014: return {31'b0, m_ien};
            12'h018: return {31'b0, m_ist};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge given the inputs presented in that cycle.
    task automatic model_step(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input bit halt);
        logic [63:0] n_cnt, n_cmp;
        bit tick, match, n_ten, n_den, n_ien, n_ist;
        logic [3:0] n_dval;
        tick = 0;
        if (!m_ten) m_phase = 0;
        else if (!m_hack) begin
            if (!m_den) tick = 1;
            else begin
                m_phase++;
                if (m_phase == (1 << m_dval)) begin tick = 1; m_phase = 0; end
            end
        end
        match = (m_cnt == m_cmp);
        n_cnt = tick ? m_cnt + 64'd1 : m_cnt;
        n_cmp = m_cmp; n_ten = m_ten; n_den = m_den; n_dval = m_dval; n_ien = m_ien;
        n_ist = m_ist | match;
        if (wr) begin
            case ({addr[11:2], 2'b00})
                12'h000: begin
                    if (strb[0]) n_ten = data[0];
                    if (!m_ten) begin
                        if (strb[0]) n_den = data[1];
                        if (strb[1] && data[11:8] <= 4'd8) n_dval = data[11:8];
                    end
                end
                12'h004: n_cnt = {m_cnt[63:32], merge32(m_cnt[31:0], data, strb)};
                12'h008: n_cnt = {merge32(m_cnt[63:32], data, strb), m_cnt[31:0]};
                12'h00C: n_cmp = {m_cmp[63:32], merge32(m_cmp[31:0], data, strb)};
                12'h010: n_cmp = {merge32(m_cmp[63:32], data, strb), m_cmp[31:0]};
                12'h014: if (strb[0]) n_ien = data[0];
                12'h018: if (strb[0] && data[0] && !match) n_ist = 0;
                default: ;
            endcase
        end
        m_cnt = n_cnt; m_cmp = n_cmp; m_ten = n_ten; m_den = n_den; m_dval = n_dval;
        m_ien = n_ien; m_ist = n_ist; m_hack = halt;
    endtask

    // One bus cycle: drive, sample mid-cycle, step the model at the edge.
    task automatic bus_cycle(input bit wr, input bit rd, input logic [11:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             output logic [31:0] rdata);
        bus.wr_en = wr; bus.rd_en = rd; bus.paddr = addr; bus.pwdata = data; bus.pstrb = strb;
        halt_req = halt_lvl;
        #3;
        rdata = bus.prdata;
        if (rd) begin
            checks++;
            if (bus.prdata !== mread(addr)) begin
                failures++;
                $display("FAIL read addr=%h got=%h exp=%h t=%0t", addr, bus.prdata, mread(addr), $time);
            end
        end
        checks++;
        if (interrupt !== (m_ist & m_ien)) begin
            failures++;
            $display("FAIL interrupt got=%b exp=%b t=%0t", interrupt, m_ist & m_ien, $time);
        end
        checks++;
        if (halt_ack !== m_hack) begin
            failures++;
            $display("FAIL halt_ack got=%b exp=%b t=%0t", halt_ack, m_hack, $time);
        end
        @(posedge clk);
        model_step(wr, addr, data, strb, halt_lvl);
        #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb = 4'hF);
        logic [31:0] d;
        bus_cycle(1'b1, 1'b0, addr, data, strb, d);
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] data);
        bus_cycle(1'b0, 1'b1, addr, 32'h0, 4'h0, data);
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, d);
    endtask

    task automatic apply_reset();
        bus.wr_en = 0; bus.rd_en = 0; bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        halt_lvl = 0; halt_req = 0;
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] d, exp;
        apply_reset();
        for (int a = 0; a <= 12'h1C; a += 4) begin
            rd(12'(a), d);
            exp = (a == 12'h00C || a == 12'h010) ? 32'hFFFF_FFFF : 32'h0;
            checks++;
            if (d !== exp) begin
                failures++;
                $display("FAIL reset_value addr=%h got=%h exp=%h", a, d, exp);
            end
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        apply_reset();
        wr(12'h000, 32'h0000_0202);
        wr(12'h000, 32'h0000_0203);
        idle(40);
        rd(12'h004, d);
        checks++;
        if (d !== 32'd10) begin
            failures++;
            $display("FAIL prescaler_count got=%0d exp=10", d);
        end
        wr(12'h000, 32'h0000_0503);
        rd(12'h000, d);
        checks++;
        if (d !== 32'h0000_0203) begin
            failures++;
            $display("FAIL div_val_locked got=%h exp=00000203", d);
        end
        // Random prescaler settings, including the rejected div_val > 8 case.
        for (int k = 0; k < 4; k++) begin
            wr(12'h000, 32'h0);
            wr(12'h000, {20'b0, 4'($urandom_range(0, 12)), 6'b0, 1'b1, 1'b0});
            wr(12'h000, 32'h0000_0001, 4'b0001);
            idle($urandom_range(20, 80));
            rd(12'h004, d);
            rd(12'h000, d);
        end
    endtask

    task automatic test_wrap_and_strobe();
        logic [31:0] d;
        apply_reset();
        wr(12'h004, 32'hFFFF_FFFF);
        wr(12'h008, 32'hFFFF_FFFF);
        wr(12'h000, 32'h0000_0001);
        rd(12'h004, d);
        rd(12'h004, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL wrap_low got=%h exp=00000000", d);
        end
        rd(12'h008, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL wrap_high got=%h exp=00000000", d);
        end
        wr(12'h004, 32'hAABB_CC55, 4'b0001);
        rd(12'h004, d);
        checks++;
        if (d !== 32'h0000_0055) begin
            failures++;
            $display("FAIL strobe_write_on_tick got=%h exp=00000055", d);
        end
        rd(12'h008, d);
    endtask

    task automatic test_compare_irq();
        logic [31:0] d;
        apply_reset();
        wr(12'h00C, 32'd5);
        wr(12'h010, 32'd0);
        wr(12'h014, 32'd1);
        wr(12'h000, 32'h0000_0001);
        idle(12);
        rd(12'h018, d);
        wr(12'h018, 32'h1, 4'b0001);
        #3;
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("FAIL w1c_clear got=%b exp=0", interrupt);
        end
        #(-3+3);
        wr(12'h000, 32'h0);
        wr(12'h004, 32'd5);
        idle(2);
        wr(12'h018, 32'h1, 4'b0001);
        rd(12'h018, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL w1c_loses_to_match got=%h exp=00000001", d);
        end
        wr(12'h014, 32'h0);
        rd(12'h018, d);
        idle(2);
    endtask

    task automatic test_halt();
        apply_reset();
        wr(12'h000, 32'h0000_0001);
        idle(5);
        halt_lvl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] d;
            rd(12'h004, d);
        end
        halt_lvl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            rd(12'h004, d);
        end
        // Prescaled counting across a halt keeps the divider phase.
        wr(12'h000, 32'h0);
        wr(12'h000, 32'h0000_0302);
        wr(12'h000, 32'h0000_0001, 4'b0001);
        idle(5);
        halt_lvl = 1'b1;
        idle(7);
        halt_lvl = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] d;
            rd(12'h004, d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, data;
        logic [11:0] addr;
        logic [3:0]  strb;
        int op;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) halt_lvl = ~halt_lvl;
            op   = $urandom_range(0, 9);
            addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7) * 4);
            data = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            if (addr == 12'h000 && $urandom_range(0, 3) != 0) data[0] = 1'b1;
            strb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            if (op < 3) bus_cycle(1'b1, 1'b0, addr, data, strb, d);
            else if (op < 7) bus_cycle(1'b0, 1'b1, addr, 32'h0, 4'h0, d);
            else bus_cycle(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, d);
        end
        halt_lvl = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        apply_reset();
        wr(12'h00C, 32'd3);
        wr(12'h010, 32'd0);
        wr(12'h014, 32'd1);
        wr(12'h000, 32'h0000_0001);
        idle(10);
        #3;
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("FAIL irq_before_reset got=%b exp=1", interrupt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("FAIL irq_async_reset got=%b exp=0", interrupt);
        end
        bus.rd_en = 1'b1;
        for (int a = 0; a <= 12'h18; a += 4) begin
            logic [31:0] exp;
            bus.paddr = 12'(a);
            #0.5;
            exp = (a == 12'h00C || a == 12'h010) ? 32'hFFFF_FFFF : 32'h0;
            checks++;
            if (bus.prdata !== exp) begin
                failures++;
                $display("FAIL async_reset_read addr=%h got=%h exp=%h", a, bus.prdata, exp);
            end
        end
        bus.rd_en = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        idle(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        halt_req = 1'b0;
        bus.wr_en = 0; bus.rd_en = 0; bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        model_reset();
        #1;
        test_reset();
        test_prescaler();
        test_wrap_and_strobe();
        test_compare_irq();
        test_halt();
        test_random();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_regs_core.md
Name: timer_regs_core

Overview:
Register bank and counting engine for the timer IP. It sits directly downstream of the APB slave interface and consumes its single-cycle wr_en/rd_en strobes together with the APB address and data. It holds the control, counter, compare and interrupt registers, runs a 64-bit up-counter with a power-of-two prescaler, and raises a level interrupt on compare match.

Parameters:
ADDR_W, 12, APB address width (paddr)
DATA_W, 32, APB data width; fixed at 32
CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the 64-bit compare register

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe from the APB slave; one cycle per access
rd_en  input  1  read strobe from the APB slave; one cycle per access
paddr  input  12  byte address; bits[1:0] are ignored
pwdata  input  32  write data
pstrb  input  4  byte strobes for write data
halt_req  input  1  debug halt request
prdata  output  32  read data, valid in the rd_en cycle
interrupt  output  1  level interrupt, equal to int_st & int_en
halt_ack  output  1  registered acknowledge of halt

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. Reset values:
  - all registers 0, except compare = CMP_RST
  - prescaler counter 0
  - prdata 0, interrupt 0, halt_ack 0
- Register map (any other offset reads 0; writes to it are ignored):
  - 0x000 TCR: [0] timer_en, [1] div_en, [11:8] div_val. Other bits read 0.
  - 0x004 TDR0: counter[31:0]
  - 0x008 TDR1: counter[63:32]
  - 0x00C TCMP0: compare[31:0]
  - 0x010 TCMP1: compare[63:32]
  - 0x014 TIER: [0] int_en
  - 0x018 TISR: [0] int_st, write-1-to-clear
- Writes: take effect on the clk edge of the wr_en cycle. Each byte lane is updated only where its pstrb bit is 1.
- Write restrictions on TCR:
  - A write to div_en/div_val while timer_en is currently 1 leaves those fields unchanged; timer_en itself is still written.
  - A write with div_val > 8 leaves div_val unchanged.
- Reads: prdata is combinational, equal to mux(paddr) when rd_en = 1, else 0. Zero wait states, matching pready = rd_en upstream. Reads have no side effects.
- Prescaler: active when timer_en = 1 and halt_ack = 0.
  - div_en = 0: a tick is generated every cycle.
  - div_en = 1: an 8-bit div_cnt increments each active cycle. A tick is generated when div_cnt == (1 << div_val) - 1, and div_cnt returns to 0 on that cycle.
  - div_val = 0 with div_en = 1 gives a tick every cycle.
  - div_cnt is cleared when timer_en = 0. div_cnt holds while halted.
- Counter: increments by 1 on each tick and wraps from 2^64-1 to 0.
  - A software write to TDR0/TDR1 in the same cycle as a tick wins: the written value is loaded and the increment is lost. Only the addressed half is written; the other half keeps its current value and is not incremented.
  - Clearing timer_en holds the counter value.
- Compare: match = (counter == compare), evaluated on the registered values.
  - Any cycle with match = 1 sets int_st on the next edge. int_st is sticky, and this is independent of timer_en.
  - A W1C (pwdata[0] = 1 with pstrb[0] = 1) clears int_st.
  - If set and W1C occur in the same cycle, the set wins and int_st stays 1.
- Interrupt: interrupt = int_st & int_en, combinational from registers. Masking with int_en does not clear int_st.
- Halt: halt_ack <= halt_req, registered with 1-cycle latency. While halt_ack = 1, counter and div_cnt freeze. Register reads and writes still work during halt.
- Reset mid-count: asserting rst_n low immediately forces all state to its reset value, including clearing a pending int_st.

Test Plan:
- Reset, then read every offset 0x000–0x018 → 0, except TCMP0 and TCMP1 → 0xFFFFFFFF. Offset 0x01C → 0. interrupt = 0.
- Write TCR = 0x0000_0203 (div_en = 1, div_val = 2), then timer_en = 1; run 40 cycles → TDR0 = 10 (one tick per 4 cycles). Then write TCR div_val = 5 with timer_en still 1 → div_val reads back 2.
- Write TDR0 = 0xFFFF_FFFF and TDR1 = 0xFFFF_FFFF, div_en = 0, enable → after 1 tick the counter reads 0x0 / 0x0 (wrap). Also write TDR0 = 0x55 with pstrb = 4'b0001 on a tick cycle → the low byte becomes 0x55 and the upper bytes hold with no increment.
- Set TCMP = 0x0000_0000_0000_0005, TIER = 1, enable with div_en = 0 → interrupt rises 1 cycle after the counter reaches 5 and stays high. W1C TISR → interrupt drops. A W1C issued in the exact match cycle → int_st stays 1.
- Hold halt_req = 1 for 10 cycles while counting → halt_ack rises 1 cycle later, the counter holds its value for the 10 cycles, and counting resumes 1 cycle after halt_req falls.
- Assert rst_n mid-count with int_st = 1 → the counter, TCR and int_st clear asynchronously, and interrupt = 0 before the next clk edge.
